// File: rtl/common_dffcam_ctrl_1i1l.sv
// Allocation and query-scheduling controller for a one-hot-addressed DFF CAM.
// Owns the valid bits, picks free/round-robin victims, and shares the query port with lookups.
//
// state   | meaning
// S_IDLE  | ready for a new insert
// S_CHECK | query port probes the captured key for a duplicate
// S_WRITE | writes the captured key into the chosen entry
module common_dffcam_ctrl_1i1l #(
  parameter int CAM_DEPTH = 8,
  parameter int CAM_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ins_valid,
  output logic                             ins_ready,
  input  logic [CAM_WIDTH-1:0]             ins_key,
  output logic                             ins_resp_valid,
  output logic [CAM_DEPTH-1:0]             ins_resp_idx_1h,
  output logic                             ins_resp_hit,
  output logic                             ins_resp_evict,
  input  logic                             lkp_valid,
  output logic                             lkp_ready,
  input  logic [CAM_WIDTH-1:0]             lkp_key,
  output logic                             lkp_resp_valid,
  output logic                             lkp_resp_hit,
  output logic [CAM_DEPTH-1:0]             lkp_resp_idx_1h,
  input  logic                             inv_valid,
  input  logic [CAM_DEPTH-1:0]             inv_idx_1h,
  input  logic                             flush,
  output logic                             cam_wen,
  output logic [CAM_DEPTH-1:0]             cam_waddr_1h,
  output logic [CAM_WIDTH-1:0]             cam_wdata,
  output logic [CAM_DEPTH-1:0]             cam_dvalid,
  output logic [CAM_WIDTH-1:0]             cam_qdata,
  input  logic [CAM_DEPTH-1:0]             cam_qaddr_1h,
  output logic [$clog2(CAM_DEPTH+1)-1:0]   count,
  output logic                             full
);

  localparam int CNT_W = $clog2(CAM_DEPTH + 1);
  localparam logic [CAM_DEPTH-1:0] ONE = CAM_DEPTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE} state_t;

  state_t               r_state, w_state_nxt;
  logic [CAM_DEPTH-1:0] r_valid, r_rr_ptr, r_target;
  logic                 r_evict;
  logic [CAM_WIDTH-1:0] r_key_q;

  logic [CAM_DEPTH-1:0] w_inv_mask, w_valid_eff, w_match, w_match_low, w_free_low;
  logic [CAM_DEPTH-1:0] w_valid_nxt;
  logic                 w_all_valid, w_ins_acc, w_lkp_acc, w_hit;
  logic [CNT_W-1:0]     w_count;

  // Entries being invalidated this cycle are neither matches nor occupied for allocation.
  assign w_inv_mask  = inv_valid ? inv_idx_1h : '0;
  assign w_valid_eff = r_valid & ~w_inv_mask;
  assign w_match     = cam_qaddr_1h & w_valid_eff;
  assign w_match_low = w_match & (~w_match + ONE);
  assign w_free_low  = ~w_valid_eff & (w_valid_eff + ONE);
  assign w_all_valid = &w_valid_eff;
  assign w_hit       = |w_match;

  assign ins_ready = (r_state == S_IDLE) & ~flush;
  assign lkp_ready = (r_state != S_CHECK) & ~flush;
  assign w_ins_acc = ins_valid & ins_ready;
  assign w_lkp_acc = lkp_valid & lkp_ready;

  assign cam_wen      = (r_state == S_WRITE);
  assign cam_waddr_1h = cam_wen ? r_target : '0;
  assign cam_wdata    = r_key_q;
  assign cam_qdata    = (r_state == S_CHECK) ? r_key_q : lkp_key;
  assign cam_dvalid   = r_valid;
  assign full         = &r_valid;
  assign count        = w_count;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < CAM_DEPTH; i++) w_count = w_count + CNT_W'(r_valid[i]);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ins_acc) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_hit ? S_IDLE : S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Per-entry priority: flush clear over write set over invalidate clear.
  always_comb begin
    w_valid_nxt = r_valid & ~w_inv_mask;
    if (r_state == S_WRITE) w_valid_nxt = w_valid_nxt | r_target;
    if (flush) w_valid_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_rr_ptr <= ONE;
      r_target <= '0;
      r_evict  <= 1'b0;
      r_key_q  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (w_ins_acc) r_key_q <= ins_key;
      if (r_state == S_CHECK && !w_hit) begin
        r_target <= w_all_valid ? r_rr_ptr : w_free_low;
        r_evict  <= w_all_valid;
      end
      if (flush)
        r_rr_ptr <= ONE;
      else if (r_state == S_WRITE && r_evict)
        r_rr_ptr <= {r_rr_ptr[CAM_DEPTH-2:0], r_rr_ptr[CAM_DEPTH-1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ins_resp_valid  <= 1'b0;
      ins_resp_idx_1h <= '0;
      ins_resp_hit    <= 1'b0;
      ins_resp_evict  <= 1'b0;
      lkp_resp_valid  <= 1'b0;
      lkp_resp_hit    <= 1'b0;
      lkp_resp_idx_1h <= '0;
    end else begin
      ins_resp_valid  <= 1'b0;
      ins_resp_idx_1h <= '0;
      ins_resp_hit    <= 1'b0;
      ins_resp_evict  <= 1'b0;
      if (!flush && r_state == S_CHECK && w_hit) begin
        ins_resp_valid  <= 1'b1;
        ins_resp_idx_1h <= w_match_low;
        ins_resp_hit    <= 1'b1;
      end else if (!flush && r_state == S_WRITE) begin
        ins_resp_valid  <= 1'b1;
        ins_resp_idx_1h <= r_target;
        ins_resp_evict  <= r_evict;
      end
      lkp_resp_valid  <= w_lkp_acc;
      lkp_resp_hit    <= w_lkp_acc & |(cam_qaddr_1h & r_valid);
      lkp_resp_idx_1h <= w_lkp_acc ? (cam_qaddr_1h & r_valid) : '0;
    end
  end

endmodule

// File: tb/tb_common_dffcam_ctrl_1i1l.sv
// Directed bench for common_dffcam_ctrl_1i1l with a behavioural DFF CAM attached.
module tb_common_dffcam_ctrl_1i1l;

  logic       clk, reset;
  logic       ins_valid, ins_ready;
  logic [7:0] ins_key;
  logic       ins_resp_valid, ins_resp_hit, ins_resp_evict;
  logic [7:0] ins_resp_idx_1h;
  logic       lkp_valid, lkp_ready;
  logic [7:0] lkp_key;
  logic       lkp_resp_valid, lkp_resp_hit;
  logic [7:0] lkp_resp_idx_1h;
  logic       inv_valid;
  logic [7:0] inv_idx_1h;
  logic       flush;
  logic       cam_wen;
  logic [7:0] cam_waddr_1h, cam_wdata, cam_dvalid, cam_qdata, cam_qaddr_1h;
  logic [3:0] count;
  logic       full;

  int checks = 0;
  int failures = 0;

  common_dffcam_ctrl_1i1l #(.CAM_DEPTH(8), .CAM_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_key(ins_key),
    .ins_resp_valid(ins_resp_valid), .ins_resp_idx_1h(ins_resp_idx_1h),
    .ins_resp_hit(ins_resp_hit), .ins_resp_evict(ins_resp_evict),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key),
    .lkp_resp_valid(lkp_resp_valid), .lkp_resp_hit(lkp_resp_hit),
    .lkp_resp_idx_1h(lkp_resp_idx_1h),
    .inv_valid(inv_valid), .inv_idx_1h(inv_idx_1h), .flush(flush),
    .cam_wen(cam_wen), .cam_waddr_1h(cam_waddr_1h), .cam_wdata(cam_wdata),
    .cam_dvalid(cam_dvalid), .cam_qdata(cam_qdata), .cam_qaddr_1h(cam_qaddr_1h),
    .count(count), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM storage: raw match, not qualified by valid.
  logic [7:0] mem [8];
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else if (cam_wen) begin
      for (int i = 0; i < 8; i++) if (cam_waddr_1h[i]) mem[i] <= cam_wdata;
    end
  end
  always_comb begin
    cam_qaddr_1h = '0;
    for (int i = 0; i < 8; i++) if (mem[i] == cam_qdata) cam_qaddr_1h[i] = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ins_valid = 0; ins_key = 0; lkp_valid = 0; lkp_key = 0;
    inv_valid = 0; inv_idx_1h = 0; flush = 0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic do_ins(input logic [7:0] key, input logic exp_hit, input logic exp_evict,
                        input logic [7:0] exp_idx, input int exp_lat, input string name);
    int   lat;
    logic saw_wen;
    ins_key = key;
    ins_valid = 1'b1;
    checks++;
    if (ins_ready !== 1'b1) begin
      failures++; $display("FAIL %s ins_ready act=%b exp=1", name, ins_ready);
    end
    step();
    ins_valid = 1'b0;
    lat = 1;
    saw_wen = 1'b0;
    while (ins_resp_valid !== 1'b1 && lat < 10) begin
      if (cam_wen === 1'b1) saw_wen = 1'b1;
      step();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++; $display("FAIL %s latency act=%0d exp=%0d", name, lat, exp_lat);
    end
    checks++;
    if (ins_resp_hit !== exp_hit) begin
      failures++; $display("FAIL %s hit act=%b exp=%b", name, ins_resp_hit, exp_hit);
    end
    checks++;
    if (ins_resp_evict !== exp_evict) begin
      failures++; $display("FAIL %s evict act=%b exp=%b", name, ins_resp_evict, exp_evict);
    end
    checks++;
    if (ins_resp_idx_1h !== exp_idx) begin
      failures++; $display("FAIL %s idx act=%h exp=%h", name, ins_resp_idx_1h, exp_idx);
    end
    checks++;
    if (ins_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_after act=%b exp=1", name, ins_ready);
    end
    if (exp_hit) begin
      checks++;
      if (saw_wen !== 1'b0) begin
        failures++; $display("FAIL %s no_wen act=%b exp=0", name, saw_wen);
      end
    end
  endtask

  task automatic do_lkp(input logic [7:0] key, input logic exp_hit, input logic [7:0] exp_idx,
                        input string name);
    lkp_key = key;
    lkp_valid = 1'b1;
    checks++;
    if (lkp_ready !== 1'b1) begin
      failures++; $display("FAIL %s lkp_ready act=%b exp=1", name, lkp_ready);
    end
    step();
    lkp_valid = 1'b0;
    checks++;
    if (lkp_resp_valid !== 1'b1) begin
      failures++; $display("FAIL %s resp_valid act=%b exp=1", name, lkp_resp_valid);
    end
    checks++;
    if (lkp_resp_hit !== exp_hit) begin
      failures++; $display("FAIL %s hit act=%b exp=%b", name, lkp_resp_hit, exp_hit);
    end
    checks++;
    if (lkp_resp_idx_1h !== exp_idx) begin
      failures++; $display("FAIL %s idx act=%h exp=%h", name, lkp_resp_idx_1h, exp_idx);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (count !== 4'd0 || full !== 1'b0) begin
      failures++; $display("FAIL reset_count act=%0d/%b exp=0/0", count, full);
    end
    checks++;
    if (ins_ready !== 1'b1 || lkp_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready act=%b%b exp=11", ins_ready, lkp_ready);
    end
    checks++;
    if (ins_resp_valid !== 1'b0 || lkp_resp_valid !== 1'b0 || cam_wen !== 1'b0) begin
      failures++; $display("FAIL reset_pulses act=%b%b%b exp=000", ins_resp_valid, lkp_resp_valid, cam_wen);
    end
    checks++;
    if (cam_dvalid !== 8'h00 || ins_resp_idx_1h !== 8'h00 || lkp_resp_idx_1h !== 8'h00) begin
      failures++; $display("FAIL reset_vectors act=%h/%h/%h exp=00/00/00", cam_dvalid, ins_resp_idx_1h, lkp_resp_idx_1h);
    end
  endtask

  task automatic test_fill_hit();
    logic [7:0] idx;
    for (int i = 0; i < 8; i++) begin
      idx = 8'h01 << i;
      do_ins(8'h11 + 8'(i), 1'b0, 1'b0, idx, 3, "fill");
    end
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      failures++; $display("FAIL fill_full act=%b/%0d exp=1/8", full, count);
    end
    do_ins(8'h13, 1'b1, 1'b0, 8'h04, 2, "rehit");
  endtask

  task automatic test_replace();
    do_ins(8'h21, 1'b0, 1'b1, 8'h01, 3, "evict0");
    do_ins(8'h22, 1'b0, 1'b1, 8'h02, 3, "evict1");
    do_ins(8'h23, 1'b0, 1'b1, 8'h04, 3, "evict2");
    do_lkp(8'h11, 1'b0, 8'h00, "lkp_evicted");
    do_lkp(8'h21, 1'b1, 8'h01, "lkp_new");
  endtask

  task automatic test_inv_race();
    do_reset();
    do_ins(8'h30, 1'b0, 1'b0, 8'h01, 3, "race_first");
    ins_key = 8'h30;
    ins_valid = 1'b1;
    step();
    ins_valid = 1'b0;
    inv_valid = 1'b1;
    inv_idx_1h = 8'h01;
    step();
    inv_valid = 1'b0;
    inv_idx_1h = 8'h00;
    checks++;
    if (ins_resp_valid !== 1'b0) begin
      failures++; $display("FAIL race_nohit act=%b exp=0", ins_resp_valid);
    end
    step();
    checks++;
    if (ins_resp_valid !== 1'b1 || ins_resp_hit !== 1'b0 || ins_resp_idx_1h !== 8'h01) begin
      failures++; $display("FAIL race_resp act=v%b h%b i%h exp=v1 h0 i01", ins_resp_valid, ins_resp_hit, ins_resp_idx_1h);
    end
    checks++;
    if (count !== 4'd1 || cam_dvalid !== 8'h01) begin
      failures++; $display("FAIL race_count act=%0d/%h exp=1/01", count, cam_dvalid);
    end
  endtask

  task automatic test_query_share();
    lkp_key = 8'h40;
    lkp_valid = 1'b1;
    ins_key = 8'h40;
    ins_valid = 1'b1;
    checks++;
    if (lkp_ready !== 1'b1) begin
      failures++; $display("FAIL share_rdy_t0 act=%b exp=1", lkp_ready);
    end
    step();
    ins_valid = 1'b0;
    checks++;
    if (lkp_ready !== 1'b0) begin
      failures++; $display("FAIL share_rdy_check act=%b exp=0", lkp_ready);
    end
    checks++;
    if (lkp_resp_valid !== 1'b1 || lkp_resp_hit !== 1'b0) begin
      failures++; $display("FAIL share_lkp_t0 act=v%b h%b exp=v1 h0", lkp_resp_valid, lkp_resp_hit);
    end
    step();
    checks++;
    if (lkp_ready !== 1'b1 || cam_wen !== 1'b1) begin
      failures++; $display("FAIL share_write act=r%b w%b exp=r1 w1", lkp_ready, cam_wen);
    end
    checks++;
    if (lkp_resp_valid !== 1'b0) begin
      failures++; $display("FAIL share_lkp_check act=%b exp=0", lkp_resp_valid);
    end
    step();
    checks++;
    if (ins_resp_valid !== 1'b1 || ins_resp_idx_1h !== 8'h02) begin
      failures++; $display("FAIL share_ins act=v%b i%h exp=v1 i02", ins_resp_valid, ins_resp_idx_1h);
    end
    checks++;
    if (lkp_resp_valid !== 1'b1 || lkp_resp_hit !== 1'b0) begin
      failures++; $display("FAIL share_lkp_write act=v%b h%b exp=v1 h0", lkp_resp_valid, lkp_resp_hit);
    end
    step();
    lkp_valid = 1'b0;
    checks++;
    if (lkp_resp_valid !== 1'b1 || lkp_resp_hit !== 1'b1 || lkp_resp_idx_1h !== 8'h02) begin
      failures++; $display("FAIL share_lkp_after act=v%b h%b i%h exp=v1 h1 i02", lkp_resp_valid, lkp_resp_hit, lkp_resp_idx_1h);
    end
  endtask

  task automatic test_flush();
    logic [7:0] idx;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idx = 8'h01 << i;
      do_ins(8'h60 + 8'(i), 1'b0, 1'b0, idx, 3, "flfill");
    end
    do_ins(8'h70, 1'b0, 1'b1, 8'h01, 3, "flevict");
    ins_key = 8'h71;
    ins_valid = 1'b1;
    step();
    ins_valid = 1'b0;
    step();
    checks++;
    if (cam_wen !== 1'b1) begin
      failures++; $display("FAIL flush_inwrite act=%b exp=1", cam_wen);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (ins_ready !== 1'b0 || lkp_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready act=%b%b exp=00", ins_ready, lkp_ready);
    end
    step();
    flush = 1'b0;
    checks++;
    if (ins_resp_valid !== 1'b0 || count !== 4'd0 || cam_dvalid !== 8'h00) begin
      failures++; $display("FAIL flush_state act=v%b c%0d d%h exp=v0 c0 d00", ins_resp_valid, count, cam_dvalid);
    end
    step();
    checks++;
    if (ins_resp_valid !== 1'b0) begin
      failures++; $display("FAIL flush_noresp act=%b exp=0", ins_resp_valid);
    end
    for (int i = 0; i < 8; i++) begin
      idx = 8'h01 << i;
      do_ins(8'h80 + 8'(i), 1'b0, 1'b0, idx, 3, "postflush");
    end
    do_ins(8'h90, 1'b0, 1'b1, 8'h01, 3, "rr_restart");
  endtask

  task automatic test_async_reset();
    lkp_key = 8'h81;
    lkp_valid = 1'b1;
    ins_key = 8'h95;
    ins_valid = 1'b1;
    step();
    lkp_valid = 1'b0;
    ins_valid = 1'b0;
    checks++;
    if (lkp_resp_valid !== 1'b1 || cam_wen !== 1'b0 || count !== 4'd8) begin
      failures++; $display("FAIL arst_pre act=v%b w%b c%0d exp=v1 w0 c8", lkp_resp_valid, cam_wen, count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (lkp_resp_valid !== 1'b0 || lkp_resp_hit !== 1'b0 || lkp_resp_idx_1h !== 8'h00) begin
      failures++; $display("FAIL arst_lkp act=v%b h%b i%h exp=v0 h0 i00", lkp_resp_valid, lkp_resp_hit, lkp_resp_idx_1h);
    end
    checks++;
    if (ins_resp_valid !== 1'b0 || cam_wen !== 1'b0 || ins_resp_idx_1h !== 8'h00) begin
      failures++; $display("FAIL arst_ins act=v%b w%b i%h exp=v0 w0 i00", ins_resp_valid, cam_wen, ins_resp_idx_1h);
    end
    checks++;
    if (count !== 4'd0 || full !== 1'b0 || cam_dvalid !== 8'h00) begin
      failures++; $display("FAIL arst_valid act=c%0d f%b d%h exp=c0 f0 d00", count, full, cam_dvalid);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (ins_ready !== 1'b1 || count !== 4'd0) begin
      failures++; $display("FAIL arst_release act=r%b c%0d exp=r1 c0", ins_ready, count);
    end
    do_ins(8'h96, 1'b0, 1'b0, 8'h01, 3, "arst_ins");
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_fill_hit();
    test_replace();
    test_inv_race();
    test_query_share();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/common_dffcam_ctrl_1i1l.md
# common_dffcam_ctrl_1i1l

Allocation and query-scheduling controller for the DFF-based CAM (`common_dffcam_1a1w1qa`, instantiated with one-hot write and query address ports). It owns the per-entry valid bits and allocates free entries to insert requests, replacing entries round-robin when the CAM is full. It time-shares the single CAM query port between duplicate-checking for inserts and an external lookup requester, and handles invalidate and flush. It sits between the CAM and its client pipeline (for example, a tag-tracking or rename structure).

## Interface
- `CAM_DEPTH`, default 8: number of entries, ≥2.
- `CAM_WIDTH`, default 8: key width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ins_valid`  in  1  insert request.
- `ins_ready`  out  1  insert accept.
- `ins_key`  in  CAM_WIDTH  key to insert.
- `ins_resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `ins_resp_idx_1h`  out  CAM_DEPTH  entry holding the key.
- `ins_resp_hit`  out  1  key was already present; no write occurred.
- `ins_resp_evict`  out  1  a valid entry was overwritten.
- `lkp_valid`  in  1  lookup request.
- `lkp_ready`  out  1  lookup accept.
- `lkp_key`  in  CAM_WIDTH  lookup key.
- `lkp_resp_valid`  out  1  one-cycle lookup result pulse.
- `lkp_resp_hit`  out  1  lookup matched a valid entry.
- `lkp_resp_idx_1h`  out  CAM_DEPTH  matched entries, masked by valid.
- `inv_valid`  in  1  invalidate request; always accepted.
- `inv_idx_1h`  in  CAM_DEPTH  entries to invalidate; any bit pattern is legal.
- `flush`  in  1  invalidate all entries and abort any in-flight insert.
- `cam_wen`  out  1  CAM write enable.
- `cam_waddr_1h`  out  CAM_DEPTH  CAM write address.
- `cam_wdata`  out  CAM_WIDTH  CAM write data.
- `cam_dvalid`  out  CAM_DEPTH  valid-bit register.
- `cam_qdata`  out  CAM_WIDTH  CAM query key.
- `cam_qaddr_1h`  in  CAM_DEPTH  raw CAM match vector, not masked by valid.
- `count`  out  $clog2(CAM_DEPTH+1)  number of valid entries.
- `full`  out  1  all entries valid.

## Operation
- **Insert FSM states:** IDLE, CHECK, WRITE.
  - `ins_ready` = (state==IDLE) & ~flush.
  - On accept, `ins_key` is captured in `key_q` and the FSM moves to CHECK.
- **CHECK** drives `cam_qdata`=`key_q` and computes match = `cam_qaddr_1h` & valid & ~(inv_valid ? inv_idx_1h : 0).
  - If match≠0: register a hit response with the lowest set bit of match, then go to IDLE.
  - Otherwise select the target and go to WRITE. The target is the lowest clear bit of valid. If valid is all ones, the target is `rr_ptr` and the evict flag is set.
- **WRITE** drives `cam_wen`=1, `cam_waddr_1h`=target, `cam_wdata`=`key_q`.
  - On the clock edge, valid[target] is set. If the cycle was an evict, `rr_ptr` rotates left by one.
  - A miss response is registered with hit=0, then the FSM goes to IDLE.
- **Query port scheduling.** CHECK owns the query port.
  - `lkp_ready` = (state≠CHECK) & ~flush.
  - An accepted lookup drives `cam_qdata`=`lkp_key` in that same cycle. Its result is registered as `cam_qaddr_1h` & valid at the accept cycle.
  - Lookup and insert acceptance are independent and may occur in the same cycle.
- **Valid update priority per entry, highest first:** flush clear, then WRITE set, then invalidate clear.
- **Flush** clears all valid bits, sets `rr_ptr`=1, forces IDLE, and drops any in-flight insert or lookup response. No `*_resp_valid` pulse is issued in the cycle after flush.
- **Counters:** `count` is the popcount of valid, from a registered or combinational reduction. `full` = &valid.
- **Reset values:** `cam_wen` is 0.
  - Registers: valid=0, state=IDLE, `rr_ptr`=1, `key_q`=0.
  - Outputs: all response valid/hit/evict signals 0, all idx outputs 0, `count`=0, `full`=0.

## Timing
- **Insert hit:** accept in cycle t, CHECK in t+1, `ins_resp_valid` in t+2, `ins_ready` high again in t+2.
- **Insert miss:** accept in t, CHECK in t+1, WRITE in t+2, response in t+3 with valid bit already set, `ins_ready` high in t+3. Sustained throughput is one insert per 3 cycles.
- **Lookup:** accept in t, response in t+1. `lkp_ready` is low only during CHECK or flush.
- A lookup accepted during WRITE sees pre-write state, so it misses on the key being written.
- An invalidate issued in cycle t takes effect at the edge ending t. It is visible to lookups accepted in t+1 onward.
- Reset asserted mid-insert aborts the insert immediately and asynchronously. All outputs go to their reset values.

## Test plan
- **Fill then hit:** reset, then insert keys 0x11..0x18 (DEPTH=8). Each response has hit=0, evict=0, idx_1h=0x01,0x02,…,0x80, latency 3. `full`=1 and `count`=8. Re-inserting 0x13 gives hit=1, idx_1h=0x04, latency 2, and no `cam_wen`.
- **Replacement:** with the CAM full, insert 0x21, 0x22, 0x23. Responses are evict=1 with idx_1h 0x01, 0x02, 0x04. A lookup of 0x11 then gives hit=0, and a lookup of 0x21 gives hit=1, idx_1h=0x01.
- **Invalidate race:** insert 0x30 into an empty CAM, then insert 0x30 again. Assert `inv_valid`, `inv_idx_1h`=0x01 during the second insert's CHECK. The response is hit=0, idx_1h=0x01, and the entry ends valid with `count`=1.
- **Query sharing:** hold `lkp_valid`=1 continuously while issuing an insert. `lkp_ready` is 0 exactly in the CHECK cycle. A lookup of the inserted key during WRITE misses, and the next lookup hits.
- **Flush mid-insert:** assert `flush` during WRITE. No response is issued, `count`=0, `rr_ptr` resets, and the next insert lands at idx_1h=0x01.
- **Async reset:** drop `reset` mid-CHECK and off-clock. All outputs are 0 immediately, and after release `ins_ready`=1 with the CAM empty.
